// File: rtl/mmio_io_hub.sv
// Memory-mapped I/O hub on the OTTER IOBUS: buffered output registers plus a
// synchronised input port with sticky rising-edge flags, maskable IRQ and cycle counter.
module mmio_io_hub #(
  parameter logic [31:0] BASE_AD     = 32'h1100_0000,
  parameter int unsigned IN_W        = 16,
  parameter int unsigned OUT_W       = 16,
  parameter int unsigned NUM_OUT     = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [31:0]               IOBUS_ADDR,
  input  logic [31:0]               IOBUS_OUT,
  input  logic                      IOBUS_WR,
  input  logic                      IOBUS_RD,
  output logic [31:0]               IOBUS_IN,
  input  logic [IN_W-1:0]           PORT_IN,
  output logic [NUM_OUT*OUT_W-1:0]  PORT_OUT,
  output logic                      INTR
);

  localparam logic [31:0] OFF_IN   = 32'h0000_0000;
  localparam logic [31:0] OFF_EDGE = 32'h0000_0004;
  localparam logic [31:0] OFF_MASK = 32'h0000_0008;
  localparam logic [31:0] OFF_CYC  = 32'h0000_000C;
  localparam logic [31:0] OUT_STEP = 32'h0000_0020;

  // Output register k lives at BASE_AD + 0x20*(k+1).
  function automatic logic [31:0] out_addr(input int unsigned k);
    return BASE_AD + OUT_STEP * 32'(k + 1);
  endfunction

  logic [IN_W-1:0]               sync_q [SYNC_STAGES];
  logic [IN_W-1:0]               sync_w;
  logic [IN_W-1:0]               prev_q;
  logic [IN_W-1:0]               edge_q, edge_d;
  logic [IN_W-1:0]               mask_q, mask_d;
  logic [IN_W-1:0]               rise_c;
  logic [NUM_OUT-1:0][OUT_W-1:0] out_q, out_d;
  logic [31:0]                   cyc_q;
  logic                          intr_q, intr_d;

  logic                          hit_in, hit_edge, hit_mask, hit_cyc;
  logic [NUM_OUT-1:0]            hit_out;
  logic                          clr_edge;
  logic                          unused_wdata;

  assign sync_w       = sync_q[SYNC_STAGES-1];
  assign PORT_OUT     = out_q;
  assign INTR         = intr_q;
  assign unused_wdata = ^IOBUS_OUT;

  // Exact-match address decode, no aliasing.
  always_comb begin
    hit_in   = (IOBUS_ADDR == BASE_AD + OFF_IN);
    hit_edge = (IOBUS_ADDR == BASE_AD + OFF_EDGE);
    hit_mask = (IOBUS_ADDR == BASE_AD + OFF_MASK);
    hit_cyc  = (IOBUS_ADDR == BASE_AD + OFF_CYC);
    hit_out  = '0;
    for (int unsigned k = 0; k < NUM_OUT; k++) begin
      hit_out[k] = (IOBUS_ADDR == out_addr(k));
    end
  end

  // Read mux; the edge read returns the pre-clear flags.
  always_comb begin
    IOBUS_IN = '0;
    if (hit_in) begin
      IOBUS_IN = 32'(sync_w);
    end else if (hit_edge) begin
      IOBUS_IN = 32'(edge_q);
    end else if (hit_mask) begin
      IOBUS_IN = 32'(mask_q);
    end else if (hit_cyc) begin
      IOBUS_IN = cyc_q;
    end else begin
      for (int unsigned k = 0; k < NUM_OUT; k++) begin
        if (hit_out[k]) begin
          IOBUS_IN = 32'(out_q[k]);
        end
      end
    end
  end

  // Next-state: a new rise in the clearing cycle survives the clear.
  always_comb begin
    clr_edge = IOBUS_RD && hit_edge;
    rise_c   = sync_w & ~prev_q;
    edge_d   = (edge_q & ~{IN_W{clr_edge}}) | rise_c;
    intr_d   = |(edge_d & mask_q);
    mask_d   = mask_q;
    out_d    = out_q;
    if (IOBUS_WR && hit_mask) begin
      mask_d = IOBUS_OUT[IN_W-1:0];
    end
    for (int unsigned k = 0; k < NUM_OUT; k++) begin
      if (IOBUS_WR && hit_out[k]) begin
        out_d[k] = IOBUS_OUT[OUT_W-1:0];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q <= '0;
      edge_q <= '0;
      mask_q <= '0;
      out_q  <= '0;
      cyc_q  <= '0;
      intr_q <= 1'b0;
    end else begin
      sync_q[0] <= PORT_IN;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_w;
      edge_q <= edge_d;
      mask_q <= mask_d;
      out_q  <= out_d;
      cyc_q  <= cyc_q + 32'd1;
      intr_q <= intr_d;
    end
  end

endmodule

// File: tb/tb_mmio_io_hub.sv
// Bench for mmio_io_hub: directed scenarios plus randomized bus/port traffic
// checked against a history-queue reference model.
module tb_mmio_io_hub;

  localparam int unsigned SS      = 2;
  localparam int unsigned NOUT    = 2;
  localparam logic [31:0] BASE    = 32'h1100_0000;

  logic        CLK;
  logic        rst;
  logic [31:0] addr, wdata;
  logic        wr, rd;
  logic [31:0] rdata;
  logic [15:0] pin;
  logic [31:0] pout;
  logic        intr;

  int total = 0;
  int bad   = 0;

  // Reference model state: m_hist[0] is the newest sampled PORT_IN.
  logic [15:0] m_hist[$];
  logic [15:0] m_edge, m_mask;
  logic [15:0] m_out[NOUT];
  logic [31:0] m_cyc;
  logic        m_intr;

  mmio_io_hub dut (
    .CLK(CLK), .RST(rst), .IOBUS_ADDR(addr), .IOBUS_OUT(wdata),
    .IOBUS_WR(wr), .IOBUS_RD(rd), .IOBUS_IN(rdata),
    .PORT_IN(pin), .PORT_OUT(pout), .INTR(intr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] r;
    r = 32'h0;
    if (a == BASE) r = 32'(m_hist[SS-1]);
    else if (a == BASE + 32'h4) r = 32'(m_edge);
    else if (a == BASE + 32'h8) r = 32'(m_mask);
    else if (a == BASE + 32'hC) r = m_cyc;
    else
      for (int k = 0; k < NOUT; k++)
        if (a == BASE + 32'(32 * (k + 1))) r = 32'(m_out[k]);
    return r;
  endfunction

  function automatic logic [31:0] m_port_out();
    return {m_out[1], m_out[0]};
  endfunction

  task automatic model_edge();
    logic [15:0] rise, en;
    if (rst) begin
      m_hist.delete();
      for (int i = 0; i <= SS; i++) m_hist.push_back(16'h0);
      m_edge = 0; m_mask = 0; m_cyc = 0; m_intr = 0;
      for (int k = 0; k < NOUT; k++) m_out[k] = 0;
    end else begin
      rise = m_hist[SS-1] & ~m_hist[SS];
      en = ((rd && addr == BASE + 32'h4) ? 16'h0 : m_edge) | rise;
      m_intr = |(en & m_mask);
      m_edge = en;
      if (wr && addr == BASE + 32'h8) m_mask = wdata[15:0];
      for (int k = 0; k < NOUT; k++)
        if (wr && addr == BASE + 32'(32 * (k + 1))) m_out[k] = wdata[15:0];
      m_cyc = m_cyc + 1;
      m_hist.push_front(pin);
      void'(m_hist.pop_back());
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
    wr = 1'b0;
    rd = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    rst = 1'b1; pin = 16'hFFFF; addr = BASE;
    tick(); tick();
    total++; if (pout !== 32'h0) begin bad++; $display("FAIL reset_port_out: got %h want %h", pout, 32'h0); end
    total++; if (intr !== 1'b0) begin bad++; $display("FAIL reset_intr: got %b want 0", intr); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_sync_read: got %h want 0", rdata); end
    rst = 1'b0;
    for (int k = 1; k <= SS; k++) begin
      tick();
      addr = BASE; #1;
      exp = (k == SS) ? 32'h0000_FFFF : 32'h0;
      total++; if (rdata !== exp) begin bad++; $display("FAIL sync_latency_%0d: got %h want %h", k, rdata, exp); end
      if (k == 1) begin
        addr = BASE + 32'hC; #1;
        total++; if (rdata !== 32'h1) begin bad++; $display("FAIL cycle_after_release: got %h want 1", rdata); end
      end
    end
  endtask

  task automatic test_output_write();
    addr = BASE + 32'h20; wdata = 32'hABCD_1234; wr = 1'b1; tick();
    total++; if (pout[15:0] !== 16'h1234) begin bad++; $display("FAIL out0_write: got %h want 1234", pout[15:0]); end
    #1;
    total++; if (rdata !== 32'h0000_1234) begin bad++; $display("FAIL out0_readback: got %h want 00001234", rdata); end
    addr = BASE + 32'h40; wdata = 32'h0000_5678; wr = 1'b1; tick();
    total++; if (pout !== 32'h5678_1234) begin bad++; $display("FAIL out1_write: got %h want 56781234", pout); end
    addr = BASE + 32'h60; wdata = 32'hFFFF_FFFF; wr = 1'b1; tick();
    addr = BASE + 32'h21; wdata = 32'hFFFF_FFFF; wr = 1'b1; tick();
    addr = BASE + 32'hC; wdata = 32'h0; wr = 1'b1; tick();
    total++; if (pout !== 32'h5678_1234) begin bad++; $display("FAIL unmapped_write: got %h want 56781234", pout); end
    addr = BASE + 32'h60; #1;
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL unmapped_read: got %h want 0", rdata); end
  endtask

  task automatic settle_and_clear(input logic [15:0] p);
    pin = p;
    repeat (SS + 2) tick();
    addr = BASE + 32'h4; rd = 1'b1; tick();
  endtask

  task automatic test_edge();
    settle_and_clear(16'h0000);
    addr = BASE + 32'h8; wdata = 32'hFFFF_0001; wr = 1'b1; tick();
    #1;
    total++; if (rdata !== 32'h1) begin bad++; $display("FAIL mask_readback: got %h want 1", rdata); end
    pin = 16'h0001;
    for (int k = 1; k <= SS + 1; k++) begin
      tick();
      if (k == SS) begin
        addr = BASE; #1;
        total++; if (rdata !== 32'h1) begin bad++; $display("FAIL rise_in_sync: got %h want 1", rdata); end
        total++; if (intr !== 1'b0) begin bad++; $display("FAIL intr_early: got %b want 0", intr); end
      end
    end
    total++; if (intr !== 1'b1) begin bad++; $display("FAIL intr_on_edge: got %b want 1", intr); end
    addr = BASE + 32'h4; rd = 1'b1; #1;
    total++; if (rdata !== 32'h1) begin bad++; $display("FAIL edge_read: got %h want 1", rdata); end
    tick(); #1;
    total++; if (intr !== 1'b0) begin bad++; $display("FAIL intr_after_clear: got %b want 0", intr); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL edge_after_clear: got %h want 0", rdata); end
    pin = 16'h0000;
    repeat (SS + 3) tick();
    #1;
    total++; if (rdata !== 32'h0 || intr !== 1'b0) begin bad++; $display("FAIL falling_edge: got edge=%h intr=%b want 0/0", rdata, intr); end
  endtask

  task automatic test_simultaneous();
    pin = 16'h0002;
    repeat (SS + 2) tick();
    pin = 16'h000A;
    repeat (SS) tick();
    addr = BASE + 32'h4; rd = 1'b1; #1;
    total++; if (rdata !== 32'h2) begin bad++; $display("FAIL simul_old_edge: got %h want 2", rdata); end
    tick(); #1;
    total++; if (rdata !== 32'h8) begin bad++; $display("FAIL simul_new_edge: got %h want 8", rdata); end
    total++; if (intr !== 1'b0) begin bad++; $display("FAIL simul_intr_masked: got %b want 0", intr); end
    rd = 1'b1; tick();
  endtask

  task automatic test_mask();
    addr = BASE + 32'h8; wdata = 32'h0; wr = 1'b1; tick();
    pin = 16'h002A;
    repeat (SS + 1) tick();
    addr = BASE + 32'h4; #1;
    total++; if (rdata !== 32'h20) begin bad++; $display("FAIL masked_edge: got %h want 20", rdata); end
    total++; if (intr !== 1'b0) begin bad++; $display("FAIL masked_intr: got %b want 0", intr); end
    addr = BASE + 32'h8; wdata = 32'h20; wr = 1'b1; tick();
    tick();
    total++; if (intr !== 1'b1) begin bad++; $display("FAIL unmask_intr: got %b want 1", intr); end
    addr = BASE + 32'h4; rd = 1'b1; tick();
    total++; if (intr !== 1'b0) begin bad++; $display("FAIL unmask_clear: got %b want 0", intr); end
  endtask

  task automatic test_random();
    logic [31:0] alist[10];
    logic [31:0] exp;
    alist = '{BASE, BASE + 32'h4, BASE + 32'h8, BASE + 32'hC, BASE + 32'h20,
              BASE + 32'h40, BASE + 32'h60, BASE + 32'h24, 32'h0, BASE + 32'h8};
    for (int i = 0; i < 400; i++) begin
      addr  = alist[$urandom_range(0, 9)];
      wdata = $urandom;
      wr    = ($urandom_range(0, 2) == 0);
      rd    = ($urandom_range(0, 2) == 0);
      pin   = pin ^ 16'($urandom & $urandom & $urandom);
      #1;
      exp = m_read(addr);
      total++; if (rdata !== exp) begin bad++; $display("FAIL rand_read[%0d] addr=%h: got %h want %h", i, addr, rdata, exp); end
      tick();
      exp = m_port_out();
      total++; if (pout !== exp) begin bad++; $display("FAIL rand_port_out[%0d]: got %h want %h", i, pout, exp); end
      total++; if (intr !== m_intr) begin bad++; $display("FAIL rand_intr[%0d]: got %b want %b", i, intr, m_intr); end
    end
  endtask

  task automatic test_wrap();
    addr = BASE + 32'hC;
    force dut.cyc_q = 32'hFFFF_FFFF;
    #1;
    release dut.cyc_q;
    m_cyc = 32'hFFFF_FFFF;
    #1;
    total++; if (rdata !== 32'hFFFF_FFFF) begin bad++; $display("FAIL cycle_deposit: got %h want ffffffff", rdata); end
    tick(); #1;
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL cycle_wrap: got %h want 0", rdata); end
    tick(); #1;
    total++; if (rdata !== 32'h1) begin bad++; $display("FAIL cycle_after_wrap: got %h want 1", rdata); end
  endtask

  task automatic test_reset_mid();
    settle_and_clear(16'h0000);
    addr = BASE + 32'h20; wdata = 32'h5555; wr = 1'b1; tick();
    addr = BASE + 32'h8; wdata = 32'h10; wr = 1'b1; tick();
    pin = 16'h0010;
    repeat (SS) tick();
    rst = 1'b1; addr = BASE + 32'h40; wdata = 32'h7777; wr = 1'b1;
    tick();
    total++; if (pout !== 32'h0) begin bad++; $display("FAIL midreset_out: got %h want 0", pout); end
    total++; if (intr !== 1'b0) begin bad++; $display("FAIL midreset_intr: got %b want 0", intr); end
    rst = 1'b0;
    addr = BASE + 32'h4; #1;
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL midreset_edge: got %h want 0", rdata); end
    addr = BASE + 32'h8; #1;
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL midreset_mask: got %h want 0", rdata); end
    tick();
    total++; if (intr !== 1'b0 || pout !== m_port_out()) begin bad++; $display("FAIL midreset_after: got intr=%b out=%h want 0/%h", intr, pout, m_port_out()); end
  endtask

  initial begin
    rst = 1'b1; addr = 32'h0; wdata = 32'h0; wr = 1'b0; rd = 1'b0; pin = 16'h0;
    m_edge = 0; m_mask = 0; m_cyc = 0; m_intr = 0;
    for (int k = 0; k < NOUT; k++) m_out[k] = 0;
    for (int i = 0; i <= SS; i++) m_hist.push_back(16'h0);
    test_reset();
    test_output_write();
    test_edge();
    test_simultaneous();
    test_mask();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
